// File: rtl/delay_line_checker.sv
// delay_line_checker: receiving end for flop-delay test circuits.
// Keeps a shift-register history of the stimulus bit d and compares each
// response q1..q3 against d delayed by that channel's expected latency.
// Reports sticky per-channel error flags, saturating compare and error
// counts, and the compare index of the first failure.
//
// Handshake: there is none. d and q1..q3 are sampled on every rising edge,
// and en qualifies checking. en low returns the FSM to IDLE. The history
// must then be refilled (LATMAX en-high edges) before comparing resumes.
// Statistics are only touched by compares, by clr and by reset.
module delay_line_checker #(
  parameter int LAT1  = 1,
  parameter int LAT2  = 2,
  parameter int LAT3  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic             d,
  input  logic             q1,
  input  logic             q2,
  input  logic             q3,
  output logic             busy,
  output logic             checking,
  output logic             err,
  output logic [2:0]       err_mask,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] first_err
);

  localparam int LAT12  = (LAT1 > LAT2) ? LAT1 : LAT2;
  localparam int LATMAX = (LAT12 > LAT3) ? LAT12 : LAT3;
  localparam int FW     = $clog2(LATMAX + 1);

  typedef enum logic [1:0] {IDLE, FILL, CHECK} state_t;

  state_t           state, state_nxt;
  logic [FW-1:0]    fill, fill_nxt;
  logic [LATMAX:1]  hist;
  logic             do_cmp;
  logic [2:0]       mismatch;

  logic [2:0]       mask_nxt;
  logic [CNT_W-1:0] err_cnt_nxt, chk_cnt_nxt, first_err_nxt;

  // History of d: hist[k] holds d as sampled k edges ago, shifts every edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist <= '0;
    end else begin
      hist[1] <= d;
      for (int k = 2; k <= LATMAX; k++) begin
        hist[k] <= hist[k-1];
      end
    end
  end

  // State and fill counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      fill  <= '0;
    end else begin
      state <= state_nxt;
      fill  <= fill_nxt;
    end
  end

  // Next-state logic: fill LATMAX valid samples, then compare every en edge.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    do_cmp    = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      fill_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          // The d sampled at this edge is the first valid history entry.
          fill_nxt  = FW'(1);
          state_nxt = (LATMAX == 1) ? CHECK : FILL;
        end
        FILL: begin
          fill_nxt = fill + FW'(1);
          if (fill_nxt == FW'(LATMAX)) state_nxt = CHECK;
        end
        CHECK: begin
          do_cmp = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
          fill_nxt  = '0;
        end
      endcase
    end
  end

  assign mismatch = {q3 ^ hist[LAT3], q2 ^ hist[LAT2], q1 ^ hist[LAT1]};

  // Statistics update: clr wins over a same-edge compare; counters saturate.
  // A zero err_mask means no mismatch has been seen since reset or clr.
  always_comb begin
    mask_nxt      = err_mask;
    err_cnt_nxt   = err_cnt;
    chk_cnt_nxt   = chk_cnt;
    first_err_nxt = first_err;
    if (clr) begin
      mask_nxt      = '0;
      err_cnt_nxt   = '0;
      chk_cnt_nxt   = '0;
      first_err_nxt = '0;
    end else if (do_cmp) begin
      if (chk_cnt != '1) chk_cnt_nxt = chk_cnt + CNT_W'(1);
      if (mismatch != 3'b000) begin
        if (err_mask == 3'b000) first_err_nxt = chk_cnt;
        mask_nxt = err_mask | mismatch;
        if (err_cnt != '1) err_cnt_nxt = err_cnt + CNT_W'(1);
      end
    end
  end

  // Statistics registers; err tracks the OR of the next-state mask.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_mask  <= '0;
      err_cnt   <= '0;
      chk_cnt   <= '0;
      first_err <= '0;
      err       <= 1'b0;
    end else begin
      err_mask  <= mask_nxt;
      err_cnt   <= err_cnt_nxt;
      chk_cnt   <= chk_cnt_nxt;
      first_err <= first_err_nxt;
      err       <= |mask_nxt;
    end
  end

  assign busy     = (state == FILL) || (state == CHECK);
  assign checking = (state == CHECK);

endmodule

// File: tb/tb_delay_line_checker.sv
// tb_delay_line_checker: drives ideal 1/2/3-cycle delays of a random d into
// the checker with selectable per-channel corruption, and scores the outputs
// against a behavioural model of the check sequence. A second instance with
// 3-bit counters and q1 permanently inverted exercises counter saturation.
module tb_delay_line_checker;

  localparam int EW = 1 + 1 + 1 + 3 + 16 * 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUT (defaults) ----------------
  logic        en = 1'b0, clr = 1'b0, d = 1'b0;
  logic        q1 = 1'b0, q2 = 1'b0, q3 = 1'b0;
  logic        busy, checking, err;
  logic [2:0]  err_mask;
  logic [15:0] err_cnt, chk_cnt, first_err;

  delay_line_checker dut (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .d(d),
    .q1(q1), .q2(q2), .q3(q3),
    .busy(busy), .checking(checking), .err(err), .err_mask(err_mask),
    .err_cnt(err_cnt), .chk_cnt(chk_cnt), .first_err(first_err)
  );

  // ---------------- DUT (3-bit counters, q1 always wrong) ----------------
  logic        en_s = 1'b1, clr_s = 1'b0;
  logic        q1_s = 1'b0, q2_s = 1'b0, q3_s = 1'b0;
  logic        busy_s, checking_s, err_s;
  logic [2:0]  err_mask_s;
  logic [2:0]  err_cnt_s, chk_cnt_s, first_err_s;

  delay_line_checker #(.CNT_W(3)) dut_sat (
    .clk(clk), .rstn(rstn), .en(en_s), .clr(clr_s), .d(d),
    .q1(q1_s), .q2(q2_s), .q3(q3_s),
    .busy(busy_s), .checking(checking_s), .err(err_s), .err_mask(err_mask_s),
    .err_cnt(err_cnt_s), .chk_cnt(chk_cnt_s), .first_err(first_err_s)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bench-side history of d, used to build ideal responses.
  logic [8:1] bh = '0;

  // Behavioural model of the checker as seen at its outputs.
  int          m_fill = 0;
  logic        m_chk = 1'b0;
  logic [2:0]  m_mask = '0;
  logic [15:0] m_errc = '0, m_chkc = '0, m_first = '0;

  task automatic model_reset();
    bh = '0;
    m_fill = 0;
    m_chk = 1'b0;
    m_mask = '0;
    m_errc = '0;
    m_chkc = '0;
    m_first = '0;
    exp_q.delete();
  endtask

  task automatic compare_out();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("busy",      32'(busy),      32'(e[53]));
      check("checking",  32'(checking),  32'(e[52]));
      check("err",       32'(err),       32'(e[51]));
      check("err_mask",  32'(err_mask),  32'(e[50:48]));
      check("err_cnt",   32'(err_cnt),   32'(e[47:32]));
      check("chk_cnt",   32'(chk_cnt),   32'(e[31:16]));
      check("first_err", 32'(first_err), 32'(e[15:0]));
    end
  endtask

  // ---------------- driver ----------------
  // One clock of stimulus; flip corrupts the matching response channels.
  task automatic step(input logic en_v, input logic clr_v, input logic [2:0] flip);
    d    = 1'($urandom_range(0, 1));
    en   = en_v;
    clr  = clr_v;
    q1   = bh[1] ^ flip[0];
    q2   = bh[2] ^ flip[1];
    q3   = bh[3] ^ flip[2];
    q1_s = ~bh[1];
    q2_s = bh[2];
    q3_s = bh[3];
    // Statistics use the pre-edge checking state.
    if (clr_v) begin
      m_mask = '0; m_errc = '0; m_chkc = '0; m_first = '0;
    end else if (en_v && m_chk) begin
      if (flip != 3'b000) begin
        if (m_mask == 3'b000) m_first = m_chkc;
        m_mask = m_mask | flip;
        m_errc = m_errc + 16'd1;
      end
      m_chkc = m_chkc + 16'd1;
    end
    if (!en_v) begin
      m_fill = 0;
      m_chk  = 1'b0;
    end else if (!m_chk) begin
      m_fill++;
      if (m_fill == 3) m_chk = 1'b1;
    end
    exp_q.push_back({en_v, m_chk, |m_mask, m_mask, m_errc, m_chkc, m_first});
    @(posedge clk);
    bh = {bh[7:1], d};
    #1;
    compare_out();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(busy),      32'd0);
    check({tag, "_chking"}, 32'(checking),  32'd0);
    check({tag, "_err"},    32'(err),       32'd0);
    check({tag, "_mask"},   32'(err_mask),  32'd0);
    check({tag, "_errc"},   32'(err_cnt),   32'd0);
    check({tag, "_chkc"},   32'(chk_cnt),   32'd0);
    check({tag, "_first"},  32'(first_err), 32'd0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    #12;
    check_all_zero("reset");
    rstn = 1'b1;
    model_reset();

    // Fill: checking rises after the 3rd en-high edge.
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b0, 3'b000);
    check("fill2_checking", 32'(checking), 32'd0);
    step(1'b1, 1'b0, 3'b000);
    check("fill3_checking", 32'(checking), 32'd1);

    // Clean compares 0 and 1; sat instance has failed both so far.
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b0, 3'b000);
    check("sat_chk_2", 32'(chk_cnt_s), 32'd2);
    check("sat_err_2", 32'(err_cnt_s), 32'd2);

    // Clean compares 2..4, then q2 corrupted at compare index 5.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'b000);
    check("clean_chk_cnt", 32'(chk_cnt), 32'd5);
    check("clean_err", 32'(err), 32'd0);
    step(1'b1, 1'b0, 3'b010);
    check("q2_mask",  32'(err_mask),  32'b010);
    check("q2_err",   32'(err),       32'd1);
    check("q2_errc",  32'(err_cnt),   32'd1);
    check("q2_first", 32'(first_err), 32'd5);
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b0, 3'b100);
    check("q3_mask",  32'(err_mask),  32'b110);
    check("q3_errc",  32'(err_cnt),   32'd2);
    check("q3_first", 32'(first_err), 32'd5);

    // en dropout with q1 corrupted across the refill window.
    step(1'b0, 1'b0, 3'b001);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_chkc", 32'(chk_cnt), 32'd8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'b001);
    check("refill_errc", 32'(err_cnt), 32'd2);
    check("refill_chkc", 32'(chk_cnt), 32'd8);
    step(1'b1, 1'b0, 3'b000);
    check("resume_chkc", 32'(chk_cnt), 32'd9);

    // Mismatch on the clr edge is discarded; the next one is index 0.
    step(1'b1, 1'b1, 3'b001);
    check("clr_mask", 32'(err_mask), 32'd0);
    check("clr_errc", 32'(err_cnt),  32'd0);
    check("clr_chkc", 32'(chk_cnt),  32'd0);
    step(1'b1, 1'b0, 3'b010);
    check("postclr_errc",  32'(err_cnt),   32'd1);
    check("postclr_first", 32'(first_err), 32'd0);

    // Randomised traffic with occasional dropouts, clears and corruption.
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
    end

    // Saturating instance: both counters pinned at all-ones.
    check("sat_errc",  32'(err_cnt_s),   32'd7);
    check("sat_chkc",  32'(chk_cnt_s),   32'd7);
    check("sat_mask",  32'(err_mask_s),  32'b001);
    check("sat_first", 32'(first_err_s), 32'd0);

    // Asynchronous reset in the middle of CHECK.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b0, 3'b001);
    rstn = 1'b0;
    #2;
    check_all_zero("async_rst");
    #2;
    rstn = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b0, 3'b000);
    check("rst_fill2_checking", 32'(checking), 32'd0);
    step(1'b1, 1'b0, 3'b000);
    check("rst_fill3_checking", 32'(checking), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3'b000);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
